uart_bp_initiator: RTL

// - Bus initiator for bus_protocol_if that drives the AHBUart peripheral port.
// - Programs baud and control, streams TX bytes into the UART and drains RX bytes out

---
 rtl/uart_bp_pkg.sv | 37 +++
 rtl/uart_bp_xfer.sv | 107 ++++++++++
 rtl/uart_bp_initiator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bp_pkg.sv
// rtl/uart_bp_pkg.sv - shared register map, FSM encoding and status bits for uart_bp_initiator
//
// Purpose: constants and types shared by the AHBUart bus initiator and its
// single-transaction engine.
package uart_bp_pkg;

  // AHBUart peripheral register map (byte addresses)
  localparam int unsigned REG_RX_DATA  = 0;
  localparam int unsigned REG_RX_STATE = 4;
  localparam int unsigned REG_TX_DATA  = 8;
  localparam int unsigned REG_TX_STATE = 12;
  localparam int unsigned REG_CTRL     = 20;
  localparam int unsigned REG_BAUD     = 24;

  // Status register bit positions
  localparam int RX_AVAIL_BIT = 0;
  localparam int TX_FULL_BIT  = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_BAUD,
    ST_CFG_CTRL,
    ST_SERVICE,
    ST_TX_POLL,
    ST_TX_WRITE,
    ST_RX_POLL,
    ST_RX_READ,
    ST_GAP
  } state_t;

  // Which side the round-robin arbiter offers the bus to first
  typedef enum logic {
    ARB_TX,
    ARB_RX
  } arb_t;

endpackage

// File: rtl/uart_bp_xfer.sv
// rtl/uart_bp_xfer.sv - single bus transaction engine with stall timeout and error abort
//
// Purpose: latches one request on start_i, drives it onto the bus from the next
// cycle, holds it through request_stall, and reports done_o (good completion,
// rdata_o valid) or fail_o (bus error or stall timeout) for exactly one cycle.
// Ports:
//   clk, nReset            clock, async active-high reset
//   start_i, we_i,         request launch (ignored while busy_o)
//   addr_i, wdata_i
//   busy_o                 a request is on the bus
//   done_o, fail_o, rdata_o  completion status; rdata_o valid with done_o
//   bp_*                   bus_protocol_if initiator side
module uart_bp_xfer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int STALL_MAX = 255
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                fail_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ADDR_W-1:0]   bp_addr_o,
  output logic                bp_wen_o,
  output logic                bp_ren_o,
  output logic [DATA_W-1:0]   bp_wdata_o,
  output logic [DATA_W/8-1:0] bp_strobe_o,
  input  logic [DATA_W-1:0]   bp_rdata_i,
  input  logic                bp_request_stall_i,
  input  logic                bp_error_i
);

  localparam int CNT_W = $clog2(STALL_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

  logic              active_q, active_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  always_comb begin
    active_d    = active_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    stall_cnt_d = stall_cnt_q;
    done_o      = 1'b0;
    fail_o      = 1'b0;

    if (!active_q) begin
      stall_cnt_d = '0;
      if (start_i) begin
        active_d = 1'b1;
        we_d     = we_i;
        addr_d   = addr_i;
        wdata_d  = wdata_i;
      end
    end else if (bp_request_stall_i) begin
      // This stall cycle would push the count past STALL_MAX: give up now.
      if (stall_cnt_q >= STALL_LIM) begin
        fail_o   = 1'b1;
        active_d = 1'b0;
      end else begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else if (bp_error_i) begin
      fail_o   = 1'b1;
      active_d = 1'b0;
    end else begin
      done_o   = 1'b1;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      active_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      active_q    <= active_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The bus sees nothing but zeros outside an active request, so the cycle
  // after any completion is always an idle gap.
  assign busy_o      = active_q;
  assign rdata_o     = bp_rdata_i;
  assign bp_addr_o   = active_q ? addr_q : '0;
  assign bp_wen_o    = active_q & we_q;
  assign bp_ren_o    = active_q & ~we_q;
  assign bp_wdata_o  = (active_q & we_q) ? wdata_q : '0;
  assign bp_strobe_o = active_q ? '1 : '0;

endmodule

// File: rtl/uart_bp_initiator.sv
// rtl/uart_bp_initiator.sv - AHBUart bus initiator: config, TX streaming, RX draining
//
// Purpose: programs BAUD/CTRL on cfg_start, then round-robins between pushing
// offered TX bytes (after a TX_STATE poll) and pulling RX bytes into a one-byte
// holding register (after an RX_STATE poll), backing off POLL_GAP cycles when
// neither side has work.
// Ports:
//   clk, nReset                 clock, async active-high reset
//   cfg_start, cfg_baud, cfg_ctrl  configuration request and values
//   tx_valid, tx_byte, tx_ready    TX byte stream in (tx_ready = accepted)
//   rx_valid, rx_byte, rx_ready    RX byte stream out
//   cfg_done, busy, err            status
//   bp_*                           bus_protocol_if initiator side
module uart_bp_initiator
  import uart_bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int POLL_GAP  = 16,
  parameter int STALL_MAX = 255
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                cfg_start,
  input  logic [31:0]         cfg_baud,
  input  logic [31:0]         cfg_ctrl,
  input  logic                tx_valid,
  input  logic [7:0]          tx_byte,
  output logic                tx_ready,
  output logic                rx_valid,
  output logic [7:0]          rx_byte,
  input  logic                rx_ready,
  output logic                cfg_done,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W-1:0]   bp_addr,
  output logic                bp_wen,
  output logic                bp_ren,
  output logic [DATA_W-1:0]   bp_wdata,
  output logic [DATA_W/8-1:0] bp_strobe,
  input  logic [DATA_W-1:0]   bp_rdata,
  input  logic                bp_request_stall,
  input  logic                bp_error
);

  localparam int GAP_W = $clog2(POLL_GAP + 1) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t           state_q, state_d;
  arb_t             rr_q, rr_d;
  logic             tx_neg_q, tx_neg_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             cfg_done_q, cfg_done_d;
  logic             err_q, err_d;

  logic              xfer_start;
  logic              xfer_we;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_wdata;
  logic              xfer_busy;
  logic              xfer_done;
  logic              xfer_fail;
  logic [DATA_W-1:0] xfer_rdata;
  logic              rdata_unused;
  logic              restart;
  logic              tx_want;
  logic              rx_want;

  uart_bp_xfer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .STALL_MAX(STALL_MAX)
  ) u_xfer (
    .clk               (clk),
    .nReset            (nReset),
    .start_i           (xfer_start),
    .we_i              (xfer_we),
    .addr_i            (xfer_addr),
    .wdata_i           (xfer_wdata),
    .busy_o            (xfer_busy),
    .done_o            (xfer_done),
    .fail_o            (xfer_fail),
    .rdata_o           (xfer_rdata),
    .bp_addr_o         (bp_addr),
    .bp_wen_o          (bp_wen),
    .bp_ren_o          (bp_ren),
    .bp_wdata_o        (bp_wdata),
    .bp_strobe_o       (bp_strobe),
    .bp_rdata_i        (bp_rdata),
    .bp_request_stall_i(bp_request_stall),
    .bp_error_i        (bp_error)
  );

  // Only the low byte of a data read carries UART payload.
  assign rdata_unused = ^xfer_rdata[DATA_W-1:8];

  // Configuration may only be (re)started while no bus transaction is owed.
  assign restart = cfg_start && (state_q == ST_IDLE || state_q == ST_SERVICE ||
                                 state_q == ST_GAP);

  // A TX side that just polled full waits out the next gap before retrying.
  assign tx_want = tx_valid && !tx_neg_q;
  assign rx_want = !rx_full_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    tx_neg_d   = tx_neg_q;
    gap_cnt_d  = gap_cnt_q;
    rx_full_d  = rx_full_q;
    rx_byte_d  = rx_byte_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    xfer_start = 1'b0;
    xfer_we    = 1'b0;
    xfer_addr  = '0;
    xfer_wdata = '0;
    tx_ready   = 1'b0;

    if (rx_full_q && rx_ready) begin
      rx_full_d = 1'b0;
    end

    // In the transaction states a new request is launched as soon as the
    // engine is idle; the engine is still busy on the completion cycle, so
    // each state launches exactly once.
    case (state_q)
      ST_IDLE: ;

      ST_CFG_BAUD: begin
        xfer_start = !xfer_busy;
        xfer_we    = 1'b1;
        xfer_addr  = ADDR_W'(REG_BAUD);
        xfer_wdata = DATA_W'(cfg_baud);
        if (xfer_done) state_d = ST_CFG_CTRL;
      end

      ST_CFG_CTRL: begin
        xfer_start = !xfer_busy;
        xfer_we    = 1'b1;
        xfer_addr  = ADDR_W'(REG_CTRL);
        xfer_wdata = DATA_W'(cfg_ctrl);
        if (xfer_done) begin
          cfg_done_d = 1'b1;
          rr_d       = ARB_TX;
          tx_neg_d   = 1'b0;
          state_d    = ST_SERVICE;
        end
      end

      ST_SERVICE: begin
        if (rr_q == ARB_TX) begin
          if (tx_want)      state_d = ST_TX_POLL;
          else if (rx_want) state_d = ST_RX_POLL;
          else              state_d = ST_GAP;
        end else begin
          if (rx_want)      state_d = ST_RX_POLL;
          else if (tx_want) state_d = ST_TX_POLL;
          else              state_d = ST_GAP;
        end
        gap_cnt_d = '0;
      end

      ST_TX_POLL: begin
        xfer_start = !xfer_busy;
        xfer_addr  = ADDR_W'(REG_TX_STATE);
        if (xfer_done) begin
          if (xfer_rdata[TX_FULL_BIT]) begin
            tx_neg_d = 1'b1;
            rr_d     = ARB_RX;
            state_d  = ST_SERVICE;
          end else begin
            state_d = ST_TX_WRITE;
          end
        end
      end

      ST_TX_WRITE: begin
        xfer_start = !xfer_busy;
        xfer_we    = 1'b1;
        xfer_addr  = ADDR_W'(REG_TX_DATA);
        xfer_wdata = DATA_W'(tx_byte);
        if (xfer_done) begin
          tx_ready = 1'b1;
          tx_neg_d = 1'b0;
          rr_d     = ARB_RX;
          state_d  = ST_SERVICE;
        end
      end

      ST_RX_POLL: begin
        xfer_start = !xfer_busy;
        xfer_addr  = ADDR_W'(REG_RX_STATE);
        if (xfer_done) begin
          if (xfer_rdata[RX_AVAIL_BIT]) begin
            state_d = ST_RX_READ;
          end else begin
            rr_d      = ARB_TX;
            gap_cnt_d = '0;
            state_d   = tx_want ? ST_SERVICE : ST_GAP;
          end
        end
      end

      ST_RX_READ: begin
        xfer_start = !xfer_busy;
        xfer_addr  = ADDR_W'(REG_RX_DATA);
        if (xfer_done) begin
          // Only reachable with the holding register empty, so no clash
          // with a consumer accept in this same cycle.
          rx_byte_d = xfer_rdata[7:0];
          rx_full_d = 1'b1;
          rr_d      = ARB_TX;
          state_d   = ST_SERVICE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          tx_neg_d = 1'b0;
          state_d  = ST_SERVICE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d    = ST_CFG_BAUD;
      cfg_done_d = 1'b0;
      err_d      = 1'b0;
    end

    if (xfer_fail) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state_q    <= ST_IDLE;
      rr_q       <= ARB_TX;
      tx_neg_q   <= 1'b0;
      gap_cnt_q  <= '0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      tx_neg_q   <= tx_neg_d;
      gap_cnt_q  <= gap_cnt_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
    end
  end

  assign rx_valid = rx_full_q;
  assign rx_byte  = rx_byte_q;
  assign cfg_done = cfg_done_q;
  assign err      = err_q;
  assign busy     = xfer_busy;

endmodule
